// File: rtl/uio_sched_pkg.sv
// Purpose: shared types and constants for the uio pad-bus scheduler.
// Contents: FSM state enum, bus width, direction encodings, output-enable patterns.
// Helper oe_for() maps a transfer direction to the matching pad output-enable word.
package uio_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int             BUS_W     = 8;
  localparam logic           DIR_READ  = 1'b0;
  localparam logic           DIR_WRITE = 1'b1;
  localparam logic [BUS_W-1:0] OE_ALL  = 8'hFF;

  // Pads drive only for writes; reads leave the bus tri-stated.
  function automatic logic [BUS_W-1:0] oe_for(input logic d);
    return (d == DIR_WRITE) ? OE_ALL : '0;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Purpose: combinational round-robin picker; first set req bit at or after ptr (mod N).
// Ports: req (request vector), ptr (start index) -> idx (selected index), vld (any request).
// Latency: zero cycles, pure combinational; no backpressure of its own.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          vld
);

  int j;

  // Scan offsets from highest to lowest so the last hit written is the
  // closest one to ptr, avoiding any early-exit construct.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    j   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        idx = PW'(j);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uio_bus_scheduler.sv
// Purpose: time-shares the bidirectional uio pad bus among NREQ requesters, round-robin,
//          with a tri-stated turnaround gap whenever the bus direction changes.
// Ports: clk/rst_n (sync active-low), ena, req/dir/wdata per requester, gnt/done/rdata/busy,
//        uio_in/uio_out/uio_oe pad side. Latency: gnt 1 cycle after request, done HOLD_CYC
//        cycles later (+TURN_CYC on direction change); requesters wait while another holds gnt.
module uio_bus_scheduler
  import uio_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int HOLD_CYC = 2,
  parameter int TURN_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   dir,
  input  logic [NREQ*8-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic              done,
  output logic [7:0]        rdata,
  output logic              busy,
  input  logic [7:0]        uio_in,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe
);

  localparam int PW   = $clog2(NREQ);
  localparam int MAXC = (HOLD_CYC > TURN_CYC) ? HOLD_CYC : TURN_CYC;
  localparam int CW   = $clog2(MAXC) + 1;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   idx_q;
  logic            dir_q;
  logic            last_dir;
  logic [7:0]      wdata_q;
  logic [CW-1:0]   cnt;

  logic [PW-1:0]   pick_idx;
  logic            pick_vld;
  logic [7:0]      wdata_arr [NREQ];
  logic [NREQ-1:0] pick_onehot;

  for (genvar i = 0; i < NREQ; i++) begin : g_wslice
    assign wdata_arr[i] = wdata[8*i +: 8];
  end

  assign pick_onehot = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;

  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_rr_pick (
    .req (req),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  // All outputs are registered and set on the edge that enters the state
  // they belong to, so the pad drive never glitches through an OE of FF in TURN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      rdata    <= '0;
      uio_out  <= '0;
      uio_oe   <= '0;
      rr_ptr   <= '0;
      last_dir <= DIR_READ;
      idx_q    <= '0;
      dir_q    <= DIR_READ;
      wdata_q  <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          gnt    <= '0;
          busy   <= 1'b0;
          uio_oe <= oe_for(last_dir);
          if (ena && pick_vld) begin
            idx_q   <= pick_idx;
            dir_q   <= dir[pick_idx];
            wdata_q <= wdata_arr[pick_idx];
            gnt     <= pick_onehot;
            busy    <= 1'b1;
            cnt     <= '0;
            if (dir[pick_idx] != last_dir) begin
              state  <= TURN;
              uio_oe <= '0;
            end else begin
              state  <= XFER;
              uio_oe <= oe_for(dir[pick_idx]);
              if (dir[pick_idx] == DIR_WRITE) begin
                uio_out <= wdata_arr[pick_idx];
              end
            end
          end
        end

        TURN: begin
          if (cnt == CW'(TURN_CYC - 1)) begin
            state  <= XFER;
            cnt    <= '0;
            uio_oe <= oe_for(dir_q);
            if (dir_q == DIR_WRITE) begin
              uio_out <= wdata_q;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        XFER: begin
          if (cnt == CW'(HOLD_CYC - 1)) begin
            state <= DONE;
            done  <= 1'b1;
            if (dir_q == DIR_READ) begin
              rdata <= uio_in;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          state    <= IDLE;
          gnt      <= '0;
          busy     <= 1'b0;
          last_dir <= dir_q;
          uio_oe   <= oe_for(dir_q);
          rr_ptr   <= (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
        end

        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uio_bus_scheduler.sv
// Purpose: directed self-checking bench for uio_bus_scheduler (NREQ=4, HOLD=2, TURN=1).
// Stimulus: hand-computed vectors for reset, read, turnaround write, round-robin, ena drop, reset abort.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_uio_bus_scheduler;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [3:0]  req;
  logic [3:0]  dir;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic        done;
  logic [7:0]  rdata;
  logic        busy;
  logic [7:0]  uio_in;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  uio_bus_scheduler #(
    .NREQ     (4),
    .HOLD_CYC (2),
    .TURN_CYC (1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .req     (req),
    .dir     (dir),
    .wdata   (wdata),
    .gnt     (gnt),
    .done    (done),
    .rdata   (rdata),
    .busy    (busy),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock; invariants are checked on every cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check("oe_legal", 32'(uio_oe == 8'h00 || uio_oe == 8'hFF), 32'd1);
    check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
  endtask

  task automatic wait_done(input int limit, output int at);
    at = -1;
    for (int n = 0; n < limit; n++) begin
      tick();
      if (done) begin
        at = cyc;
        break;
      end
    end
    check("done_seen", 32'(at >= 0), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int at;
    int prev;
    int t0;
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};

    rst_n  = 1'b0;
    ena    = 1'b1;
    req    = '0;
    dir    = '0;
    wdata  = '0;
    uio_in = '0;

    // Reset / idle
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_uio_out", 32'(uio_out), 32'h0);
    check("rst_uio_oe", 32'(uio_oe), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_oe", 32'(uio_oe), 32'h0);
      check("idle_busy", 32'(busy), 32'h0);
    end

    // Single read from requester 2, no turnaround
    req    = 4'b0100;
    dir    = 4'b0000;
    uio_in = 8'hA5;
    tick();
    check("rd_gnt", 32'(gnt), 32'h4);
    check("rd_busy", 32'(busy), 32'h1);
    check("rd_oe1", 32'(uio_oe), 32'h0);
    req = 4'b0000;
    tick();
    check("rd_done_early", 32'(done), 32'h0);
    check("rd_oe2", 32'(uio_oe), 32'h0);
    tick();
    check("rd_done", 32'(done), 32'h1);
    check("rd_rdata", 32'(rdata), 32'hA5);
    check("rd_gnt_done", 32'(gnt), 32'h4);
    uio_in = 8'h00;
    tick();
    check("rd_done_pulse", 32'(done), 32'h0);
    check("rd_rdata_hold", 32'(rdata), 32'hA5);
    check("rd_gnt_clr", 32'(gnt), 32'h0);
    check("rd_idle_oe", 32'(uio_oe), 32'h0);

    // Write from requester 1 with turnaround; rr_ptr is 3 so scan is 3,0,1
    req   = 4'b0010;
    dir   = 4'b0010;
    wdata = 32'h0000_3C00;
    tick();
    check("wr_gnt", 32'(gnt), 32'h2);
    check("wr_turn_oe", 32'(uio_oe), 32'h0);
    // Late changes to request inputs must not affect the latched transaction.
    req   = 4'b0000;
    dir   = 4'b0000;
    wdata = 32'h0;
    tick();
    check("wr_x1_oe", 32'(uio_oe), 32'hFF);
    check("wr_x1_out", 32'(uio_out), 32'h3C);
    check("wr_x1_done", 32'(done), 32'h0);
    tick();
    check("wr_x2_out", 32'(uio_out), 32'h3C);
    check("wr_x2_done", 32'(done), 32'h0);
    tick();
    check("wr_done", 32'(done), 32'h1);
    check("wr_done_oe", 32'(uio_oe), 32'hFF);
    tick();
    check("wr_idle_gnt", 32'(gnt), 32'h0);
    check("wr_idle_oe", 32'(uio_oe), 32'hFF);
    tick();
    check("wr_park_oe", 32'(uio_oe), 32'hFF);

    // Round-robin fairness from a fresh reset (rr_ptr=0, last_dir=read)
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    req   = 4'b1111;
    dir   = 4'b1111;
    wdata = 32'h4433_2211;
    t0    = cyc;
    prev  = -1;
    for (int k = 0; k < 5; k++) begin
      wait_done(12, at);
      check("rr_gnt", 32'(gnt), 32'(1 << exp_order[k]));
      check("rr_data", 32'(uio_out), 32'(8'h11 * (exp_order[k] + 1)));
      if (k == 0) check("rr_first_lat", 32'(at - t0), 32'd4);
      else        check("rr_spacing", 32'(at - prev), 32'd4);
      prev = at;
    end
    req = 4'b0000;
    tick();
    check("rr_idle", 32'(busy), 32'h0);

    // ena drop during requester 3's transfer (rr_ptr=1, last_dir=write)
    req   = 4'b1000;
    wdata = 32'h5A00_0000;
    tick();
    check("ena_gnt", 32'(gnt), 32'h8);
    ena = 1'b0;
    tick();
    tick();
    check("ena_done", 32'(done), 32'h1);
    check("ena_out", 32'(uio_out), 32'h5A);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("ena_hold_gnt", 32'(gnt), 32'h0);
      check("ena_hold_busy", 32'(busy), 32'h0);
    end
    ena = 1'b1;
    tick();
    check("ena_regnt", 32'(gnt), 32'h8);
    req = 4'b0000;
    wait_done(8, at);
    tick();

    // Complete one write on requester 2 so rr_ptr moves to 3
    req   = 4'b0100;
    wdata = 32'h0077_0000;
    tick();
    check("ab_gnt1", 32'(gnt), 32'h4);
    req = 4'b0000;
    wait_done(8, at);
    tick();

    // Reset in the middle of requester 2's write
    req = 4'b0100;
    tick();
    check("ab_gnt2", 32'(gnt), 32'h4);
    tick();
    check("ab_xfer_oe", 32'(uio_oe), 32'hFF);
    rst_n = 1'b0;
    tick();
    check("ab_gnt", 32'(gnt), 32'h0);
    check("ab_oe", 32'(uio_oe), 32'h0);
    check("ab_busy", 32'(busy), 32'h0);
    check("ab_done", 32'(done), 32'h0);
    check("ab_out", 32'(uio_out), 32'h0);
    rst_n = 1'b1;
    req   = 4'b1111;
    dir   = 4'b1111;
    wdata = 32'h4433_2299;
    tick();
    check("ab_ptr0_gnt", 32'(gnt), 32'h1);
    check("ab_turn_oe", 32'(uio_oe), 32'h0);
    req = 4'b0000;
    wait_done(8, at);
    check("ab_done_gnt", 32'(gnt), 32'h1);
    check("ab_done_out", 32'(uio_out), 32'h99);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uio_bus_scheduler.md
Name: uio_bus_scheduler

Overview:
- Time-shares the bidirectional uio pad bus of tt_um_s_grundner among NREQ internal requesters.
- Each requester asks for one read or one write transaction on the bus.
- The block arbitrates round-robin, inserts a bus-turnaround gap on every direction change, and drives uio_out and uio_oe itself.
- Sits between the top-level pad ports and the functional units inside the user project.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- HOLD_CYC, 2, cycles the bus is held per transaction; must be >=1.
- TURN_CYC, 1, idle cycles (uio_oe=0) inserted when the direction changes; must be >=1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; synchronous, active-low.
- ena  in  1  design enable. Low: no new transaction starts.
- req  in  NREQ  per-requester request level.
- dir  in  NREQ  per-requester direction; 0 = read, 1 = write.
- wdata  in  NREQ*8  per-requester write data; slice i = bits [8i+7:8i].
- gnt  out  NREQ  one-hot grant, held for the whole transaction.
- done  out  1  single-cycle completion pulse.
- rdata  out  8  read result; valid from the done cycle and held until the next read completes.
- busy  out  1  high in every state except IDLE.
- uio_in  in  8  pad input path.
- uio_out  out  8  pad output path.
- uio_oe  out  8  pad output enable; 1 = output.

Behaviour:
- Reset values (applied at the first clk edge with rst_n=0):
  - state=IDLE, gnt=0, done=0, busy=0, rdata=0, uio_out=0, uio_oe=0.
  - rr_ptr=0, last_dir=0 (read).
- States: IDLE, TURN, XFER, DONE.
- IDLE:
  - Bus parked: uio_oe=8'hFF if last_dir=1, else 8'h00. uio_out keeps its last value.
  - If ena=1 and any req bit is set, select the first set index scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - Latch idx, dir[idx] and wdata[idx].
  - Next state is TURN if dir[idx]!=last_dir, else XFER.
  - gnt[idx] rises on that same edge.
- TURN:
  - uio_oe=0. Count TURN_CYC cycles, then go to XFER.
- XFER:
  - Write: uio_oe=8'hFF, uio_out=latched wdata.
  - Read: uio_oe=0, and rdata<=uio_in on the last XFER cycle.
  - After HOLD_CYC cycles go to DONE.
- DONE:
  - done=1 for exactly this cycle; gnt is still high; bus drive is the same as XFER.
  - On exit: rr_ptr<=(idx+1) mod NREQ, last_dir<=latched dir, gnt<=0, go to IDLE.
- Latency, request seen in IDLE at cycle 0:
  - Same direction: gnt visible at cycle 1, done at cycle HOLD_CYC+1.
  - Direction change: add TURN_CYC.
  - At least one IDLE cycle between back-to-back transactions.
- Boundary rules:
  - req or dir or wdata changing after the grant: ignored, because the transaction uses latched values.
  - ena falling mid-transaction: the current transaction completes; no new one starts while ena=0.
  - rst_n low in any state: reset values on the next edge, and any transaction in flight is aborted.
  - Pointer wrap: index NREQ-1 followed by 0.
  - A single requester holding req permanently is served every HOLD_CYC+2 cycles (same direction).
  - rr_ptr advances only on completion.
- Invariants:
  - gnt is one-hot or zero.
  - uio_oe is 8'h00 or 8'hFF only.
  - uio_oe is never 8'hFF in TURN.

Decomposition:
- Shared package uio_sched_pkg holds:
  - state enum (IDLE, TURN, XFER, DONE);
  - BUS_W=8;
  - DIR_READ=0 and DIR_WRITE=1;
  - OE_ALL=8'hFF.
- One combinational sub-module, rr_pick, takes req and rr_ptr and returns the selected index plus a valid flag. It is reusable by other arbiters in the design.
- The FSM and counters stay in uio_bus_scheduler.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles, then 1, with req=0 -> all outputs 0, busy=0; uio_oe stays 8'h00 for 10 cycles.
- Single read: after reset, req[2]=1, dir[2]=0, uio_in=8'hA5 -> gnt=4'b0100 at cycle 1, no TURN, done at cycle 3, rdata=8'hA5, uio_oe=0 throughout.
- Write with turnaround: after the read, req[1]=1, dir[1]=1, wdata[1]=8'h3C -> one TURN cycle with uio_oe=0, then uio_out=8'h3C and uio_oe=8'hFF for 2 cycles; done at cycle 4; uio_oe stays 8'hFF in IDLE afterwards.
- Round-robin fairness: req=4'b1111 held, all writes -> grants in order 0,1,2,3,0, each done 4 cycles apart.
- ena drop: ena=0 during XFER of requester 3 -> that transaction completes with done=1; with req still high, no further gnt until ena=1.
- Reset mid-write: rst_n=0 during XFER -> next edge gives gnt=0, uio_oe=0, rr_ptr=0; after release, req[0] is served first.
